layer_sequencer: RTL and testbench

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/nn_pkg.sv | 14 +
 rtl/layer_sequencer_if.sv | 27 ++
 rtl/layer_sequencer.sv | 104 ++++++++++
 tb/tb_layer_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types for the layer sequencer: FSM state encoding and the index-width helper.
package nn_pkg;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_SEND = 1'b1
    } seq_state_t;

    // Index width for n entries, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Bundle of the parallel-capture and serial-output signals of layer_sequencer.
// Carries out_ready only when LAYER_SEQ_BACKPRESSURE_EN is defined.
interface layer_sequencer_if #(
    parameter int NN        = 30,
    parameter int dataWidth = 16
);
    logic [NN-1:0]           in_valid;
    logic [NN*dataWidth-1:0] in_data;
    logic                    out_valid;
    logic [dataWidth-1:0]    out_data;
    logic                    busy;
    logic                    done;
    logic                    overrun;
`ifdef LAYER_SEQ_BACKPRESSURE_EN
    logic                    out_ready;

    modport master (output in_valid, in_data, out_ready,
                    input  out_valid, out_data, busy, done, overrun);
    modport slave  (input  in_valid, in_data, out_ready,
                    output out_valid, out_data, busy, done, overrun);
`else
    modport master (output in_valid, in_data,
                    input  out_valid, out_data, busy, done, overrun);
    modport slave  (input  in_valid, in_data,
                    output out_valid, out_data, busy, done, overrun);
`endif
endinterface

// File: rtl/layer_sequencer.sv
// Captures NN parallel neuron outputs and streams them one word per transfer to the next layer.
// Optional out_ready backpressure is enabled by defining LAYER_SEQ_BACKPRESSURE_EN.
module layer_sequencer
    import nn_pkg::*;
#(
    parameter int NN        = 30,
    parameter int dataWidth = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           in_valid,
    input  logic [NN*dataWidth-1:0] in_data,
`ifdef LAYER_SEQ_BACKPRESSURE_EN
    input  logic                    out_ready,
`endif
    output logic                    out_valid,
    output logic [dataWidth-1:0]    out_data,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun
);

    localparam int unsigned      IDX_W    = idx_width(NN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);

    seq_state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0]     r_idx, w_idx_nxt;
    logic [dataWidth-1:0] r_words [NN];
    logic [dataWidth-1:0] r_out_data;
    logic                 r_overrun;

    logic w_capture, w_advance, w_last, w_load, w_overrun_set;

    assign w_capture = &in_valid;
`ifdef LAYER_SEQ_BACKPRESSURE_EN
    assign w_advance = (r_state == SEQ_SEND) && out_ready;
`else
    assign w_advance = (r_state == SEQ_SEND);
`endif
    assign w_last = w_advance && (r_idx == LAST_IDX);

    // NOTE: registers use <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEQ_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // NOTE: every output of this block is assigned a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_load        = 1'b0;
        w_overrun_set = 1'b0;
        unique case (r_state)
            SEQ_IDLE: begin
                if (w_capture) begin
                    w_state_nxt = SEQ_SEND;
                    w_idx_nxt   = '0;
                    w_load      = 1'b1;
                end
            end
            SEQ_SEND: begin
                if (w_last) begin
                    // A capture landing on the final transfer chains straight into the next pass.
                    w_idx_nxt = '0;
                    if (w_capture) w_load = 1'b1;
                    else           w_state_nxt = SEQ_IDLE;
                end else begin
                    if (w_advance) w_idx_nxt = r_idx + 1'b1;
                    if (w_capture) w_overrun_set = 1'b1;
                end
            end
        endcase
    end

    // NOTE: the capture bank is reset because its cleared contents are part of the defined reset state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NN; i++) r_words[i] <= '0;
            r_out_data <= '0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_load) begin
                for (int i = 0; i < NN; i++) r_words[i] <= in_data[i*dataWidth +: dataWidth];
                r_out_data <= in_data[dataWidth-1:0];
            end else if (w_advance && !w_last) begin
                r_out_data <= r_words[w_idx_nxt];
            end
            if (w_overrun_set) r_overrun <= 1'b1;
        end
    end

    assign out_valid = (r_state == SEQ_SEND);
    assign busy      = (r_state == SEQ_SEND);
    assign done      = w_last;
    assign out_data  = r_out_data;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer against a queue-based reference model.
module tb_layer_sequencer;

    localparam int NN = 6;
    localparam int DW = 16;
    localparam int VW = DW + 4;

    logic clk = 1'b0;
    logic rst;
    logic ready;

    always #5 clk = ~clk;

    layer_sequencer_if #(.NN(NN), .dataWidth(DW)) bus ();

    layer_sequencer #(.NN(NN), .dataWidth(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_data   (bus.in_data),
`ifdef LAYER_SEQ_BACKPRESSURE_EN
        .out_ready (bus.out_ready),
`endif
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data),
        .busy      (bus.busy),
        .done      (bus.done),
        .overrun   (bus.overrun)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: words still to be sent, last word sent, sticky overrun.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_last = '0;
    logic          m_ovr  = 1'b0;

    function automatic logic [VW-1:0] exp_vec();
        logic          act = (m_q.size() != 0);
        logic [DW-1:0] d   = act ? m_q[0] : m_last;
        return {act, act, act && ready && (m_q.size() == 1), m_ovr, d};
    endfunction

    function automatic logic [VW-1:0] act_vec();
        return {bus.busy, bus.out_valid, bus.done, bus.overrun, bus.out_data};
    endfunction

    function automatic logic [NN*DW-1:0] pack_seq(input logic [DW-1:0] base);
        logic [NN*DW-1:0] v;
        for (int i = 0; i < NN; i++) v[i*DW +: DW] = base + DW'(i + 1);
        return v;
    endfunction

    function automatic logic [NN*DW-1:0] rand_data();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drive(input logic r, input logic [NN-1:0] v, input logic [NN*DW-1:0] d,
                         input logic rdy);
        rst          = r;
        bus.in_valid = v;
        bus.in_data  = d;
        ready        = rdy;
`ifdef LAYER_SEQ_BACKPRESSURE_EN
        bus.out_ready = rdy;
`endif
    endtask

    task automatic model_edge();
        if (rst) begin
            m_q.delete();
            m_last = '0;
            m_ovr  = 1'b0;
        end else begin
            if (m_q.size() != 0 && ready) m_last = m_q.pop_front();
            if (&bus.in_valid) begin
                if (m_q.size() == 0)
                    for (int i = 0; i < NN; i++) m_q.push_back(bus.in_data[i*DW +: DW]);
                else
                    m_ovr = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b1, '0, '0, 1'b1);
        tick();
        tick();
        #1;
        total++;
        if (act_vec() !== {VW{1'b0}}) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", act_vec(), {VW{1'b0}});
        end
        drive(1'b0, '0, '0, 1'b1);
        tick();
    endtask

    task automatic test_single_pass();
        int n_valid = 0;
        int n_done  = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 0) drive(1'b0, '1, pack_seq(16'h0000), 1'b1);
            else        drive(1'b0, NN'($urandom_range(0, 31)), rand_data(), 1'b1);
            #1;
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL single_pass cyc=%0d got=%h want=%h", c, act_vec(), exp_vec());
            end
            if (bus.out_valid === 1'b1) n_valid++;
            if (bus.done === 1'b1) n_done++;
            tick();
        end
        total++;
        if (n_valid != NN || n_done != 1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL single_pass_counts valid=%0d done=%0d busy=%b want 6 1 0",
                     n_valid, n_done, bus.busy);
        end
    endtask

    task automatic test_partial();
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 6'h1F, rand_data(), 1'b1);
            #1;
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL partial cyc=%0d got=%h want=%h", c, act_vec(), exp_vec());
            end
            tick();
        end
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.overrun !== 1'b0) begin
            bad++;
            $display("FAIL partial_idle valid=%b overrun=%b want 0 0", bus.out_valid, bus.overrun);
        end
    endtask

    task automatic test_overrun();
        bit injected = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 0) drive(1'b0, '1, pack_seq(16'h0000), 1'b1);
            else if (!injected && m_q.size() != 0 && m_q[0] == 16'h0003) begin
                drive(1'b0, '1, pack_seq(16'h0040), 1'b1);
                injected = 1;
            end else drive(1'b0, '0, rand_data(), 1'b1);
            #1;
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL overrun cyc=%0d got=%h want=%h", c, act_vec(), exp_vec());
            end
            tick();
        end
        #1;
        total++;
        if (bus.overrun !== 1'b1 || !injected) begin
            bad++;
            $display("FAIL overrun_sticky overrun=%b injected=%0d want 1 1", bus.overrun, injected);
        end
    endtask

    task automatic test_back_to_back();
        bit injected = 0;
        drive(1'b1, '0, '0, 1'b1);
        tick();
        for (int c = 0; c < 16; c++) begin
            if (c == 0) drive(1'b0, '1, pack_seq(16'h0000), 1'b1);
            else if (!injected && m_q.size() == 1) begin
                drive(1'b0, '1, pack_seq(16'h0010), 1'b1);
                injected = 1;
            end else drive(1'b0, '0, rand_data(), 1'b1);
            #1;
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL back_to_back cyc=%0d got=%h want=%h", c, act_vec(), exp_vec());
            end
            tick();
            if (injected && c > 0 && bus.in_valid == '1) begin
                #1;
                total++;
                if (bus.out_data !== 16'h0011 || bus.busy !== 1'b1 || bus.overrun !== 1'b0) begin
                    bad++;
                    $display("FAIL back_to_back_chain data=%h busy=%b overrun=%b want 0011 1 0",
                             bus.out_data, bus.busy, bus.overrun);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit hit    = 0;
        int n_done = 0;
        for (int c = 0; c < 16; c++) begin
            if (c == 0) drive(1'b0, '1, pack_seq(16'h0020), 1'b1);
            else if (c == 8) drive(1'b0, '1, pack_seq(16'h0030), 1'b1);
            else if (!hit && m_q.size() != 0 && m_q[0] == 16'h0024) begin
                drive(1'b1, '0, rand_data(), 1'b1);
                hit = 1;
            end else drive(1'b0, '0, rand_data(), 1'b1);
            #1;
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL reset_mid cyc=%0d got=%h want=%h", c, act_vec(), exp_vec());
            end
            if (c < 8 && bus.done === 1'b1) n_done++;
            tick();
            if (rst) begin
                #1;
                total++;
                if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== 16'h0000) begin
                    bad++;
                    $display("FAIL reset_mid_abort valid=%b busy=%b data=%h want 0 0 0000",
                             bus.out_valid, bus.busy, bus.out_data);
                end
            end
        end
        total++;
        if (n_done != 0 || !hit) begin
            bad++;
            $display("FAIL reset_mid_done done=%0d hit=%0d want 0 1", n_done, hit);
        end
    endtask

`ifdef LAYER_SEQ_BACKPRESSURE_EN
    task automatic test_backpressure();
        int stall  = 0;
        int n_done = 0;
        drive(1'b1, '0, '0, 1'b1);
        tick();
        for (int c = 0; c < 16; c++) begin
            if (stall == 0 && m_q.size() != 0 && m_q[0] == 16'h0002 && c < 5) stall = 3;
            if (c == 0) drive(1'b0, '1, pack_seq(16'h0000), 1'b1);
            else        drive(1'b0, '0, rand_data(), (stall > 0) ? 1'b0 : 1'b1);
            #1;
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL backpressure cyc=%0d got=%h want=%h", c, act_vec(), exp_vec());
            end
            if (stall > 0) begin
                total++;
                if (bus.out_data !== 16'h0002 || bus.out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL backpressure_hold data=%h valid=%b want 0002 1",
                             bus.out_data, bus.out_valid);
                end
                stall = (stall == 1) ? -1 : stall - 1;
            end
            if (bus.done === 1'b1) n_done++;
            tick();
        end
        total++;
        if (n_done != 1) begin
            bad++;
            $display("FAIL backpressure_done done=%0d want 1", n_done);
        end
    endtask
`endif

    task automatic test_random();
        logic          r;
        logic [NN-1:0] v;
        logic          rdy;
        for (int c = 0; c < 400; c++) begin
            r = ($urandom_range(0, 49) == 0);
            v = ($urandom_range(0, 3) == 0) ? '1 : NN'($urandom());
`ifdef LAYER_SEQ_BACKPRESSURE_EN
            rdy = ($urandom_range(0, 3) != 0);
`else
            rdy = 1'b1;
`endif
            drive(r, v, rand_data(), rdy);
            #1;
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h want=%h", c, act_vec(), exp_vec());
            end
            tick();
        end
    endtask

    initial begin
        drive(1'b1, '0, '0, 1'b1);
        test_reset();
        test_single_pass();
        test_partial();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
`ifdef LAYER_SEQ_BACKPRESSURE_EN
        test_backpressure();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
